str_full_adder: RTL and testbench

Single-bit full adder built structurally from gate primitives, with registered sum and carry outputs. It adds three 1-bit operands `a`, `b` and carry-in `c`, producing sum `s` and carry-out `co`. It is the leaf cell for ripple-carry arithmetic in the datapath and is also the gate-level reference cell for structural-style checks.

---
 rtl/str_full_adder.sv | 43 ++++
 tb/tb_str_full_adder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/str_full_adder.sv
// Single-bit full adder assembled from two gate-level half adders and an OR gate,
// with the sum and carry-out captured in flops behind a synchronous reset.

module sfa_half_adder (
    input  wire x,
    input  wire y,
    output wire sum,
    output wire carry
);
    xor u_xor (sum, x, y);
    and u_and (carry, x, y);
endmodule

module str_full_adder (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    wire p;
    wire g1;
    wire sum;
    wire g2;
    wire carry;

    // First stage propagates/generates on a,b; second folds in the carry-in.
    sfa_half_adder u_ha1 (.x(a), .y(b), .sum(p),   .carry(g1));
    sfa_half_adder u_ha2 (.x(p), .y(c), .sum(sum), .carry(g2));
    or u_or (carry, g1, g2);

    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= 1'b0;
            co <= 1'b0;
        end else begin
            s  <= sum;
            co <= carry;
        end
    end
endmodule

// File: tb/tb_str_full_adder.sv
// Bench for str_full_adder: truth-table vectors and corner sequences checked
// through a scoreboard queue of expected {s,co} values.

module tb_str_full_adder;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic s;
        logic co;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic s;
    logic co;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_q[$];
    vec_t       vecs[8];

    str_full_adder dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .s  (s),
        .co (co)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expected result is queued at the same time.
    task automatic applyStimulus(input logic ir, input logic ia, input logic ib,
                                 input logic ic, input logic es, input logic eco);
        @(negedge clk);
        rst = ir;
        a   = ia;
        b   = ib;
        c   = ic;
        exp_q.push_back({es, eco});
    endtask

    task automatic checkOutput(input string tag);
        logic [1:0] e;
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: scoreboard empty, got s=%b co=%b", tag, s, co);
        end else begin
            e = exp_q.pop_front();
            if ({s, co} !== e) begin
                bad++;
                $display("[TB] FAIL %s: got s=%b co=%b, want s=%b co=%b", tag, s, co, e[1], e[0]);
            end
        end
    endtask

    task automatic step(input logic ir, input logic ia, input logic ib, input logic ic,
                        input logic es, input logic eco, input string tag);
        applyStimulus(ir, ia, ib, ic, es, eco);
        checkOutput(tag);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{a:0, b:0, c:0, s:0, co:0};
        vecs[1] = '{a:0, b:0, c:1, s:1, co:0};
        vecs[2] = '{a:0, b:1, c:0, s:1, co:0};
        vecs[3] = '{a:0, b:1, c:1, s:0, co:1};
        vecs[4] = '{a:1, b:0, c:0, s:1, co:0};
        vecs[5] = '{a:1, b:0, c:1, s:0, co:1};
        vecs[6] = '{a:1, b:1, c:0, s:0, co:1};
        vecs[7] = '{a:1, b:1, c:1, s:1, co:1};

        rst = 1'b1;
        a   = 1'b1;
        b   = 1'b1;
        c   = 1'b1;

        step(1, 1, 1, 1, 0, 0, "reset_1");
        step(1, 1, 1, 1, 0, 0, "reset_2");

        // Each vector held for 100 ns (10 clocks) and checked every cycle.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 10; k++) begin
                step(0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].co,
                     $sformatf("sweep_%0d%0d%0d", vecs[i].a, vecs[i].b, vecs[i].c));
            end
        end

        step(0, 0, 0, 0, 0, 0, "latency_pre");
        a = 1'b1;
        b = 1'b1;
        c = 1'b1;
        #3;
        total++;
        if ({s, co} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL latency_hold: got s=%b co=%b, want s=0 co=0", s, co);
        end
        exp_q.push_back(2'b11);
        checkOutput("latency_edge");

        step(0, 0, 0, 1, 1, 0, "b2b_001");
        step(0, 1, 1, 0, 0, 1, "b2b_110");
        step(0, 1, 0, 1, 0, 1, "b2b_101");
        step(0, 0, 1, 0, 1, 0, "b2b_010");

        step(0, 1, 1, 1, 1, 1, "midrst_pre");
        step(1, 1, 1, 1, 0, 0, "midrst_assert");
        step(0, 1, 1, 1, 1, 1, "midrst_release");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
